// File: rtl/wave_meas.sv
// wave_meas: threshold-crossing waveform analyser.
// Measures the number of valid samples between successive rising crossings
// of THRESH, tracks the peak and trough over that window, and converts the
// period into a phase-increment estimate floor(2^ACC_W / period) using a
// bit-serial restoring divider.
module wave_meas #(
   parameter logic [7:0] THRESH = 8'd128,
   parameter int         ACC_W  = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [7:0]       wave_in,
   input  logic             in_valid,
   input  logic             clr,
   output logic [15:0]      period,
   output logic [ACC_W-1:0] freq_word,
   output logic [7:0]       wave_max,
   output logic [7:0]       wave_min,
   output logic             result_valid,
   output logic             busy,
   output logic             overrun,
   output logic             timeout
);

   typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE, DONE} state_t;

   // The divider steps ACC_W+1 times, so its step counter must hold ACC_W.
   localparam int            CW       = $clog2(ACC_W + 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(ACC_W);
   localparam logic [CW-1:0] DIV_ONE  = CW'(1);

   state_t            state;
   logic [7:0]        prev_sample;
   logic              have_prev;
   logic [15:0]       cnt;
   logic [7:0]        cur_max;
   logic [7:0]        cur_min;
   logic [15:0]       per_lat;
   logic [7:0]        max_lat;
   logic [7:0]        min_lat;
   logic [CW-1:0]     div_cnt;
   logic [16:0]       rem;
   logic [ACC_W:0]    quo;

   logic              crossing;
   logic [15:0]       cnt_inc;
   logic [7:0]        max_next;
   logic [7:0]        min_next;
   logic [17:0]       rem_sh;
   logic              rem_ge;

   // Crossing detect, saturating count, running extrema and one divider step.
   // The dividend is 1 followed by ACC_W zeros, so the bit shifted in is
   // only set on the first step.
   always_comb begin
      crossing = in_valid && have_prev && (prev_sample < THRESH) && (wave_in >= THRESH);
      cnt_inc  = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
      max_next = (wave_in > cur_max) ? wave_in : cur_max;
      min_next = (wave_in < cur_min) ? wave_in : cur_min;
      rem_sh   = {rem, (div_cnt == DIV_LAST)};
      rem_ge   = (rem_sh >= {2'b00, per_lat});
   end

   // Main controller: sample tracking runs in every state but IDLE, while the
   // FSM hands each closed period to the divider and publishes the result.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= IDLE;
         prev_sample  <= 8'd0;
         have_prev    <= 1'b0;
         cnt          <= 16'd0;
         cur_max      <= 8'd0;
         cur_min      <= 8'd0;
         per_lat      <= 16'd0;
         max_lat      <= 8'd0;
         min_lat      <= 8'd0;
         div_cnt      <= '0;
         rem          <= 17'd0;
         quo          <= '0;
         period       <= 16'd0;
         freq_word    <= '0;
         wave_max     <= 8'd0;
         wave_min     <= 8'd0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
         overrun      <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         if (clr) begin
            state     <= IDLE;
            have_prev <= 1'b0;
            cnt       <= 16'd0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            timeout   <= 1'b0;
         end else begin
            if (in_valid) begin
               prev_sample <= wave_in;
               have_prev   <= 1'b1;
            end

            if (crossing) begin
               cnt     <= 16'd1;
               cur_max <= wave_in;
               cur_min <= wave_in;
            end else if (in_valid && (state != IDLE)) begin
               cnt     <= cnt_inc;
               cur_max <= max_next;
               cur_min <= min_next;
               if (cnt_inc == 16'hFFFF) begin
                  timeout <= 1'b1;
               end
            end

            case (state)
               IDLE: begin
                  if (crossing) begin
                     state <= MEASURE;
                  end
               end
               MEASURE: begin
                  if (crossing) begin
                     per_lat <= cnt;
                     max_lat <= cur_max;
                     min_lat <= cur_min;
                     rem     <= 17'd0;
                     quo     <= '0;
                     div_cnt <= DIV_LAST;
                     busy    <= 1'b1;
                     state   <= DIVIDE;
                  end
               end
               DIVIDE: begin
                  rem <= rem_ge ? 17'(rem_sh - {2'b00, per_lat}) : rem_sh[16:0];
                  quo <= {quo[ACC_W-1:0], rem_ge};
                  if (div_cnt == '0) begin
                     busy  <= 1'b0;
                     state <= DONE;
                  end else begin
                     div_cnt <= div_cnt - DIV_ONE;
                  end
                  if (crossing) begin
                     overrun <= 1'b1;
                  end
               end
               DONE: begin
                  period       <= per_lat;
                  freq_word    <= quo[ACC_W] ? '1 : quo[ACC_W-1:0];
                  wave_max     <= max_lat;
                  wave_min     <= min_lat;
                  result_valid <= 1'b1;
                  state        <= MEASURE;
                  if (crossing) begin
                     overrun <= 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_wave_meas.sv
// tb_wave_meas: directed self-checking bench for wave_meas.
module tb_wave_meas;

   localparam int ACC_W = 16;

   logic             clk = 1'b0;
   logic             rstn;
   logic [7:0]       wave_in;
   logic             in_valid;
   logic             clr;
   logic [15:0]      period;
   logic [ACC_W-1:0] freq_word;
   logic [7:0]       wave_max;
   logic [7:0]       wave_min;
   logic             result_valid;
   logic             busy;
   logic             overrun;
   logic             timeout;

   int n_checks = 0;
   int n_fails  = 0;
   int cyc = 0;
   int res_count = 0;
   int first_res_cyc = 0;
   int last_res_cyc = 0;
   int prev_res_cyc = 0;
   int xcyc = 0;

   wave_meas #(.THRESH(8'd128), .ACC_W(ACC_W)) dut (
      .clk(clk),
      .rstn(rstn),
      .wave_in(wave_in),
      .in_valid(in_valid),
      .clr(clr),
      .period(period),
      .freq_word(freq_word),
      .wave_max(wave_max),
      .wave_min(wave_min),
      .result_valid(result_valid),
      .busy(busy),
      .overrun(overrun),
      .timeout(timeout)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Cycle counter used to time result strobes
   always @(posedge clk) cyc <= cyc + 1;

   // Result monitor: counts strobes and remembers when they happened
   always @(negedge clk) begin
      if (result_valid === 1'b1) begin
         res_count = res_count + 1;
         prev_res_cyc = last_res_cyc;
         last_res_cyc = cyc;
         if (res_count == 1) first_res_cyc = cyc;
      end
   end

   // Hang guard
   initial begin
      #1500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_fails = n_fails + 1;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] s, input logic v);
      @(negedge clk);
      wave_in  = s;
      in_valid = v;
      clr      = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(8'd0, 1'b0);
   endtask

   task automatic doClear();
      @(negedge clk);
      in_valid = 1'b0;
      clr      = 1'b1;
      @(negedge clk);
      clr      = 1'b0;
      res_count = 0;
   endtask

   initial begin
      logic [7:0] s;
      rstn = 1'b0; clr = 1'b0; in_valid = 1'b0; wave_in = 8'd0;
      $display("[TB] start");
      repeat (3) @(negedge clk);
      checkOutput("rst_period", 32'(period), 0);
      checkOutput("rst_freq", 32'(freq_word), 0);
      checkOutput("rst_max", 32'(wave_max), 0);
      checkOutput("rst_min", 32'(wave_min), 0);
      checkOutput("rst_rv", 32'(result_valid), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_ovr", 32'(overrun), 0);
      checkOutput("rst_tmo", 32'(timeout), 0);
      rstn = 1'b1;
      res_count = 0;

      // Sawtooth 0,4,...,252 continuous: crossings at samples 32,96,160,224,288
      for (int i = 0; i < 320; i++) begin
         s = 8'(i * 4);
         applyStimulus(s, 1'b1);
         if (i == 96) xcyc = cyc;
      end
      idle(25);
      checkOutput("saw_count", res_count, 4);
      checkOutput("saw_period", 32'(period), 64);
      checkOutput("saw_freq", 32'(freq_word), 1024);
      checkOutput("saw_max", 32'(wave_max), 252);
      checkOutput("saw_min", 32'(wave_min), 0);
      checkOutput("saw_spacing", last_res_cyc - prev_res_cyc, 64);
      // sample captured one edge after being driven, result ACC_W+2 edges later
      checkOutput("saw_latency", first_res_cyc - xcyc, ACC_W + 3);
      checkOutput("saw_ovr", 32'(overrun), 0);

      // Same sawtooth with in_valid toggling 1/0
      doClear();
      for (int i = 0; i < 320; i++) begin
         s = 8'(i * 4);
         applyStimulus(s, 1'b1);
         applyStimulus(s, 1'b0);
      end
      idle(25);
      checkOutput("tog_count", res_count, 4);
      checkOutput("tog_period", 32'(period), 64);
      checkOutput("tog_freq", 32'(freq_word), 1024);
      checkOutput("tog_max", 32'(wave_max), 252);
      checkOutput("tog_spacing", last_res_cyc - prev_res_cyc, 128);

      // Square period 4 (0,0,255,255): divide is longer than a period
      doClear();
      for (int r = 0; r < 20; r++) begin
         applyStimulus(8'd0, 1'b1);
         applyStimulus(8'd0, 1'b1);
         applyStimulus(8'd255, 1'b1);
         applyStimulus(8'd255, 1'b1);
      end
      idle(25);
      checkOutput("sq4_count", res_count, 4);
      checkOutput("sq4_period", 32'(period), 4);
      checkOutput("sq4_freq", 32'(freq_word), 16384);
      checkOutput("sq4_ovr", 32'(overrun), 1);

      // Square 0x00 x5 / 0xFF x5
      doClear();
      checkOutput("clr_ovr", 32'(overrun), 0);
      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < 5; k++) applyStimulus(8'h00, 1'b1);
         for (int k = 0; k < 5; k++) applyStimulus(8'hFF, 1'b1);
      end
      idle(25);
      checkOutput("sq10_count", res_count, 3);
      checkOutput("sq10_period", 32'(period), 10);
      checkOutput("sq10_freq", 32'(freq_word), 6553);
      checkOutput("sq10_max", 32'(wave_max), 255);
      checkOutput("sq10_min", 32'(wave_min), 0);

      // Saturation: one crossing then a long run of zeros
      doClear();
      applyStimulus(8'd0, 1'b1);
      applyStimulus(8'd200, 1'b1);
      for (int k = 0; k < 65533; k++) applyStimulus(8'd0, 1'b1);
      idle(1);
      checkOutput("tmo_before", 32'(timeout), 0);
      applyStimulus(8'd0, 1'b1);
      idle(1);
      checkOutput("tmo_at", 32'(timeout), 1);
      for (int k = 0; k < 4466; k++) applyStimulus(8'd0, 1'b1);
      idle(5);
      checkOutput("tmo_nores", res_count, 0);
      checkOutput("tmo_hold", 32'(timeout), 1);
      applyStimulus(8'd200, 1'b1);
      idle(25);
      checkOutput("tmo_count", res_count, 1);
      checkOutput("tmo_period", 32'(period), 32'h0000FFFF);
      checkOutput("tmo_freq", 32'(freq_word), 1);
      checkOutput("tmo_max", 32'(wave_max), 200);

      // clr together with a crossing: crossing ignored, flags cleared
      applyStimulus(8'd0, 1'b1);
      @(negedge clk);
      wave_in = 8'd200; in_valid = 1'b1; clr = 1'b1;
      idle(1);
      checkOutput("clrx_tmo", 32'(timeout), 0);
      checkOutput("clrx_ovr", 32'(overrun), 0);
      res_count = 0;
      applyStimulus(8'd0, 1'b1);
      applyStimulus(8'd0, 1'b1);
      applyStimulus(8'd200, 1'b1);
      applyStimulus(8'd0, 1'b1);
      applyStimulus(8'd200, 1'b1);
      idle(25);
      checkOutput("clrx_count", res_count, 1);
      checkOutput("clrx_period", 32'(period), 2);
      checkOutput("clrx_freq", 32'(freq_word), 32768);

      // Reset in the middle of a divide
      res_count = 0;
      applyStimulus(8'd0, 1'b1);
      applyStimulus(8'd200, 1'b1);
      applyStimulus(8'd0, 1'b1);
      applyStimulus(8'd0, 1'b1);
      applyStimulus(8'd200, 1'b1);
      idle(5);
      checkOutput("mid_busy", 32'(busy), 1);
      checkOutput("mid_rv", 32'(result_valid), 0);
      rstn = 1'b0;
      #1;
      checkOutput("mid_period", 32'(period), 0);
      checkOutput("mid_freq", 32'(freq_word), 0);
      checkOutput("mid_max", 32'(wave_max), 0);
      checkOutput("mid_busy0", 32'(busy), 0);
      @(negedge clk);
      rstn = 1'b1;
      idle(30);
      checkOutput("mid_nores", res_count, 0);
      applyStimulus(8'd200, 1'b1);
      applyStimulus(8'd0, 1'b1);
      applyStimulus(8'd0, 1'b1);
      applyStimulus(8'd200, 1'b1);
      applyStimulus(8'd0, 1'b1);
      applyStimulus(8'd0, 1'b1);
      applyStimulus(8'd200, 1'b1);
      idle(25);
      checkOutput("post_count", res_count, 1);
      checkOutput("post_period", 32'(period), 3);
      checkOutput("post_freq", 32'(freq_word), 21845);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/wave_meas.md
WAVE_MEAS -- requirements
Module: wave_meas

Interface
REQ-001 Parameter: THRESH, default 8'd128, crossing threshold applied to wave_in.
REQ-002 Parameter: ACC_W, default 16, phase-accumulator width used for the frequency-word estimate.
REQ-003 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port: rstn  input  1  asynchronous active-low reset.
REQ-005 Port: wave_in  input  8  unsigned waveform sample, e.g. wave_sin, wave_squ, wave_tri or wave_saw.
REQ-006 Port: in_valid  input  1  wave_in is a new sample this cycle.
REQ-007 Port: clr  input  1  synchronous restart to IDLE; clears the sticky flags.
REQ-008 Port: period  output  16  samples between the last two rising crossings.
REQ-009 Port: freq_word  output  ACC_W  estimated phase increment, floor(2^ACC_W / period).
REQ-010 Port: wave_max  output  8  largest sample in the measured period.
REQ-011 Port: wave_min  output  8  smallest sample in the measured period.
REQ-012 Port: result_valid  output  1  one-cycle strobe when the period, freq_word, wave_max and wave_min outputs update.
REQ-013 Port: busy  output  1  high while the divider runs.
REQ-014 Port: overrun  output  1  sticky; a crossing was dropped while busy.
REQ-015 Port: timeout  output  1  sticky; the sample counter saturated at 16'hFFFF.

Function
REQ-016 Only cycles with in_valid=1 advance sample logic; prev_sample register holds the last valid sample.
REQ-017 Rising crossing = in_valid & prev_sample < THRESH & wave_in >= THRESH; first valid sample after reset/clr only loads prev_sample.
REQ-018 States: IDLE, MEASURE, DIVIDE, DONE.
REQ-019 IDLE: wait for crossing -> MEASURE; on entry set cnt=1 and max=min=wave_in.
REQ-020 MEASURE: each valid non-crossing sample -> cnt+1 saturating, max/min updated; on crossing latch per_lat=cnt, max_lat, min_lat, restart cnt=1, max=min=wave_in -> DIVIDE.
REQ-021 cnt reaching 16'hFFFF -> timeout=1, cnt holds; next crossing still latches 16'hFFFF.
REQ-022 DIVIDE: restoring serial divide of 2^ACC_W by per_lat, one quotient bit per clk, exactly ACC_W+1 cycles; busy=1; quotient exceeding ACC_W bits saturates to all-ones.
REQ-023 Sample counting and min/max tracking continue in parallel during DIVIDE and DONE.
REQ-024 Crossing during DIVIDE/DONE: overrun=1, per_lat and divider unchanged, cnt restarts at 1 (period discarded).
REQ-025 DONE: single cycle; period<=per_lat, freq_word<=quotient, wave_max/wave_min<=latched, result_valid=1 -> MEASURE.
REQ-026 Latency: result_valid asserted ACC_W+2 clk after the closing crossing sample cycle.
REQ-027 Outputs hold between results; result_valid low except in DONE.
REQ-028 clr has priority over all sample events; same-cycle clr and crossing -> IDLE, crossing ignored.
REQ-029 Minimum measurable period 2; period 2 gives freq_word 2^(ACC_W-1).

Reset
REQ-030 rstn low: state IDLE; period, freq_word, wave_max, wave_min = 0; result_valid, busy, overrun, timeout = 0; cnt, prev_sample, divider registers = 0.
REQ-031 Reset asserted mid-DIVIDE aborts the divide, no result_valid; after release the block requires a fresh first crossing.

Verification
REQ-032 Sawtooth 0,4,8,...,252 wrapping, in_valid=1 -> period=64, freq_word=1024, wave_max=252, wave_min=0, result_valid pulses every 64 samples after the first.
REQ-033 Square 0x00 x5 / 0xFF x5 repeating -> period=10, freq_word=6553, wave_max=255, wave_min=0.
REQ-034 in_valid toggling 1/0 on the sawtooth stimulus -> same results as continuous input; result spacing 128 clk.
REQ-035 Square period 4 (0,0,255,255), ACC_W=16 -> crossings every 4 samples, divide 17 cycles -> overrun=1, results only for undropped periods, period=4, freq_word=16384.
REQ-036 Constant wave_in=0 for 70000 samples after one crossing -> timeout=1 at 65535 samples, no result_valid; a subsequent crossing yields period=16'hFFFF, freq_word=1.
REQ-037 rstn pulsed low during DIVIDE -> all outputs 0 immediately, no result_valid; clr with crossing in same cycle -> IDLE, overrun/timeout cleared.
